// File: rtl/hemaia_mem_sb_arbiter.sv
// Super-bank arbiter: wide port owns all banks by default; a streak limit forces narrow cycles.
// Optional saturating stall counters are built when HEMAIA_SB_ARB_STATS_EN is defined.
module hemaia_mem_sb_arbiter #(
    parameter int unsigned NarrowDataWidth = 64,
    parameter int unsigned WideDataWidth   = 512,
    parameter int unsigned MemAddrWidth    = 10,
    parameter int unsigned MaxWideStreak   = 4,
    localparam int unsigned NumBanks    = WideDataWidth / NarrowDataWidth,
    localparam int unsigned NarrowStrbW = NarrowDataWidth / 8,
    localparam int unsigned StreakWidth =
        (MaxWideStreak > 0) ? $clog2(MaxWideStreak + 1) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
`ifdef HEMAIA_SB_ARB_STATS_EN
    input  logic                                stat_clear_i,
    output logic [31:0]                         stat_wide_stall_o,
    output logic [31:0]                         stat_narrow_stall_o,
`endif
    input  logic                                wide_q_valid_i,
    output logic                                wide_q_ready_o,
    input  logic                                wide_q_write_i,
    input  logic [MemAddrWidth-1:0]             wide_q_addr_i,
    input  logic [WideDataWidth-1:0]            wide_q_data_i,
    input  logic [WideDataWidth/8-1:0]          wide_q_strb_i,
    output logic                                wide_p_valid_o,
    output logic [WideDataWidth-1:0]            wide_p_data_o,
    input  logic [NumBanks-1:0]                 narrow_q_valid_i,
    output logic [NumBanks-1:0]                 narrow_q_ready_o,
    input  logic [NumBanks-1:0]                 narrow_q_write_i,
    input  logic [NumBanks*MemAddrWidth-1:0]    narrow_q_addr_i,
    input  logic [NumBanks*NarrowDataWidth-1:0] narrow_q_data_i,
    input  logic [NumBanks*NarrowStrbW-1:0]     narrow_q_strb_i,
    output logic [NumBanks-1:0]                 narrow_p_valid_o,
    output logic [NumBanks*NarrowDataWidth-1:0] narrow_p_data_o,
    output logic [NumBanks-1:0]                 bank_cs_o,
    output logic [NumBanks-1:0]                 bank_wen_o,
    output logic [NumBanks*MemAddrWidth-1:0]    bank_addr_o,
    output logic [NumBanks*NarrowStrbW-1:0]     bank_be_o,
    output logic [NumBanks*NarrowDataWidth-1:0] bank_wdata_o,
    input  logic [NumBanks*NarrowDataWidth-1:0] bank_rdata_i
);

    typedef enum logic {
        WIDE_PRIO    = 1'b0,
        NARROW_FORCE = 1'b1
    } state_e;

    localparam logic [StreakWidth-1:0] StreakMax = StreakWidth'(MaxWideStreak);

    state_e                 state_q, state_d;
    logic [StreakWidth-1:0] streak_q, streak_d;
    logic                   rsp_wide_q, rsp_wide_d;
    logic [NumBanks-1:0]    rsp_narrow_q, rsp_narrow_d;

    logic                   wide_gnt;
    logic [NumBanks-1:0]    narrow_gnt;
    logic                   narrow_blocked;

    always_comb begin
        wide_gnt       = (state_q == WIDE_PRIO) && wide_q_valid_i;
        narrow_gnt     = wide_gnt ? '0 : narrow_q_valid_i;
        narrow_blocked = |(narrow_q_valid_i & ~narrow_gnt);
        wide_q_ready_o   = wide_gnt;
        narrow_q_ready_o = narrow_gnt;
        rsp_wide_d       = wide_gnt;
        rsp_narrow_d     = narrow_gnt;
    end

    // Streak only counts wide grants that actually held off a narrow requester.
    always_comb begin
        state_d  = WIDE_PRIO;
        streak_d = '0;
        if (wide_gnt && narrow_blocked && (MaxWideStreak > 0)) begin
            streak_d = streak_q + StreakWidth'(1);
            if (streak_d == StreakMax) begin
                state_d = NARROW_FORCE;
            end
        end
    end

    always_comb begin
        bank_cs_o    = '0;
        bank_wen_o   = '0;
        bank_addr_o  = '0;
        bank_be_o    = '0;
        bank_wdata_o = '0;
        for (int j = 0; j < NumBanks; j++) begin
            if (wide_gnt) begin
                bank_cs_o[j]  = 1'b1;
                bank_wen_o[j] = wide_q_write_i;
                bank_addr_o[j*MemAddrWidth+:MemAddrWidth] = wide_q_addr_i;
                bank_be_o[j*NarrowStrbW+:NarrowStrbW] =
                    wide_q_strb_i[j*NarrowStrbW+:NarrowStrbW];
                bank_wdata_o[j*NarrowDataWidth+:NarrowDataWidth] =
                    wide_q_data_i[j*NarrowDataWidth+:NarrowDataWidth];
            end else if (narrow_gnt[j]) begin
                bank_cs_o[j]  = 1'b1;
                bank_wen_o[j] = narrow_q_write_i[j];
                bank_addr_o[j*MemAddrWidth+:MemAddrWidth] =
                    narrow_q_addr_i[j*MemAddrWidth+:MemAddrWidth];
                bank_be_o[j*NarrowStrbW+:NarrowStrbW] =
                    narrow_q_strb_i[j*NarrowStrbW+:NarrowStrbW];
                bank_wdata_o[j*NarrowDataWidth+:NarrowDataWidth] =
                    narrow_q_data_i[j*NarrowDataWidth+:NarrowDataWidth];
            end
        end
    end

    always_comb begin
        wide_p_valid_o   = rsp_wide_q;
        narrow_p_valid_o = rsp_narrow_q;
        wide_p_data_o    = '0;
        narrow_p_data_o  = '0;
        for (int j = 0; j < NumBanks; j++) begin
            if (rsp_wide_q) begin
                wide_p_data_o[j*NarrowDataWidth+:NarrowDataWidth] =
                    bank_rdata_i[j*NarrowDataWidth+:NarrowDataWidth];
            end
            if (rsp_narrow_q[j]) begin
                narrow_p_data_o[j*NarrowDataWidth+:NarrowDataWidth] =
                    bank_rdata_i[j*NarrowDataWidth+:NarrowDataWidth];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= WIDE_PRIO;
            streak_q     <= '0;
            rsp_wide_q   <= 1'b0;
            rsp_narrow_q <= '0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            rsp_wide_q   <= rsp_wide_d;
            rsp_narrow_q <= rsp_narrow_d;
        end
    end

`ifdef HEMAIA_SB_ARB_STATS_EN
    logic [31:0] stat_wide_q, stat_wide_d;
    logic [31:0] stat_narrow_q, stat_narrow_d;

    always_comb begin
        stat_wide_d   = stat_wide_q;
        stat_narrow_d = stat_narrow_q;
        if (stat_clear_i) begin
            stat_wide_d   = '0;
            stat_narrow_d = '0;
        end else begin
            if (wide_q_valid_i && !wide_gnt && (stat_wide_q != '1)) begin
                stat_wide_d = stat_wide_q + 32'd1;
            end
            if (narrow_blocked && (stat_narrow_q != '1)) begin
                stat_narrow_d = stat_narrow_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_wide_q   <= '0;
            stat_narrow_q <= '0;
        end else begin
            stat_wide_q   <= stat_wide_d;
            stat_narrow_q <= stat_narrow_d;
        end
    end

    assign stat_wide_stall_o   = stat_wide_q;
    assign stat_narrow_stall_o = stat_narrow_q;
`else
    // Statistics counters not built; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_hemaia_mem_sb_arbiter.sv
// Bench: two arbiters (MaxWideStreak 4 and 0) on shared random stimulus vs a reference model.
// Stall counters are also checked when HEMAIA_SB_ARB_STATS_EN is defined.
module tb_hemaia_mem_sb_arbiter;
    localparam int NB = 8;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int WW = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            wv, ww;
    logic [AW-1:0]   wa;
    logic [WW-1:0]   wd;
    logic [WW/8-1:0] ws;
    logic [NB-1:0]   nv, nw;
    logic [NB*AW-1:0] na;
    logic [NB*DW-1:0] nd;
    logic [NB*8-1:0]  ns;
    logic [NB*DW-1:0] rdata;
    logic             clr;

    logic             w_rdy [2];
    logic             w_pv  [2];
    logic [WW-1:0]    w_pd  [2];
    logic [NB-1:0]    n_rdy [2];
    logic [NB-1:0]    n_pv  [2];
    logic [NB*DW-1:0] n_pd  [2];
    logic [NB-1:0]    cs    [2];
    logic [NB-1:0]    wen   [2];
    logic [NB*AW-1:0] addr  [2];
    logic [NB*8-1:0]  be    [2];
    logic [NB*DW-1:0] wdat  [2];
`ifdef HEMAIA_SB_ARB_STATS_EN
    logic [31:0]      st_w_o [2];
    logic [31:0]      st_n_o [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        hemaia_mem_sb_arbiter #(
            .MaxWideStreak((g == 0) ? 4 : 0)
        ) u_dut (
            .clk_i              (clk),
            .rst_ni             (rst_n),
`ifdef HEMAIA_SB_ARB_STATS_EN
            .stat_clear_i       (clr),
            .stat_wide_stall_o  (st_w_o[g]),
            .stat_narrow_stall_o(st_n_o[g]),
`endif
            .wide_q_valid_i     (wv),
            .wide_q_ready_o     (w_rdy[g]),
            .wide_q_write_i     (ww),
            .wide_q_addr_i      (wa),
            .wide_q_data_i      (wd),
            .wide_q_strb_i      (ws),
            .wide_p_valid_o     (w_pv[g]),
            .wide_p_data_o      (w_pd[g]),
            .narrow_q_valid_i   (nv),
            .narrow_q_ready_o   (n_rdy[g]),
            .narrow_q_write_i   (nw),
            .narrow_q_addr_i    (na),
            .narrow_q_data_i    (nd),
            .narrow_q_strb_i    (ns),
            .narrow_p_valid_o   (n_pv[g]),
            .narrow_p_data_o    (n_pd[g]),
            .bank_cs_o          (cs[g]),
            .bank_wen_o         (wen[g]),
            .bank_addr_o        (addr[g]),
            .bank_be_o          (be[g]),
            .bank_wdata_o       (wdat[g]),
            .bank_rdata_i       (rdata)
        );
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model: per-DUT count of consecutive blocked wide grants.
    int          max_s [2] = '{4, 0};
    int          blk   [2];
    bit          frc   [2];
    bit          rvw   [2];
    bit [NB-1:0] rvn   [2];
    longint      stw   [2];
    longint      stn   [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            blk[d] = 0; frc[d] = 0; rvw[d] = 0; rvn[d] = '0;
            stw[d] = 0; stn[d] = 0;
        end
    endtask

    task automatic idle();
        wv = 0; ww = 0; wa = '0; wd = '0; ws = '0;
        nv = '0; nw = '0; na = '0; nd = '0; ns = '0; clr = 0;
    endtask

    task automatic rand_in();
        wv = ($urandom_range(0, 9) < 6);
        ww = 1'($urandom);
        wa = AW'($urandom);
        for (int k = 0; k < WW / 32; k++) wd[k*32+:32] = $urandom;
        for (int k = 0; k < WW / 256; k++) ws[k*32+:32] = $urandom;
        nv = NB'($urandom) & NB'($urandom);
        nw = NB'($urandom);
        for (int k = 0; k < NB; k++) begin
            na[k*AW+:AW] = AW'($urandom);
            nd[k*DW+:DW] = {$urandom, $urandom};
            ns[k*8+:8]   = 8'($urandom);
        end
        clr = ($urandom_range(0, 49) == 0);
    endtask

    // Called right after inputs are driven on the falling edge.
    task automatic eval();
        bit              wg;
        bit [NB-1:0]     ng;
        logic [NB-1:0]   ecs, ewen;
        logic [NB*AW-1:0] eaddr;
        logic [NB*8-1:0]  ebe;
        logic [NB*DW-1:0] ewd, enpd;
        string s;
        for (int k = 0; k < NB; k++) rdata[k*DW+:DW] = {$urandom, $urandom};
        #1;
        for (int d = 0; d < 2; d++) begin
            s = $sformatf("[%0d]", d);
            wg = !frc[d] && wv;
            ng = wg ? '0 : nv;
            ecs = '0; ewen = '0; eaddr = '0; ebe = '0; ewd = '0;
            if (wg) begin
                ecs = '1; ewen = {NB{ww}}; eaddr = {NB{wa}}; ebe = ws; ewd = wd;
            end else begin
                for (int j = 0; j < NB; j++) if (ng[j]) begin
                    ecs[j] = 1; ewen[j] = nw[j];
                    eaddr[j*AW+:AW] = na[j*AW+:AW];
                    ebe[j*8+:8] = ns[j*8+:8];
                    ewd[j*DW+:DW] = nd[j*DW+:DW];
                end
            end
            enpd = '0;
            for (int j = 0; j < NB; j++) if (rvn[d][j]) enpd[j*DW+:DW] = rdata[j*DW+:DW];
            check({"wide_ready", s}, 512'(w_rdy[d]), 512'(wg));
            check({"narrow_ready", s}, 512'(n_rdy[d]), 512'(ng));
            check({"bank_cs", s}, 512'(cs[d]), 512'(ecs));
            check({"bank_wen", s}, 512'(wen[d]), 512'(ewen));
            check({"bank_addr", s}, 512'(addr[d]), 512'(eaddr));
            check({"bank_be", s}, 512'(be[d]), 512'(ebe));
            check({"bank_wdata", s}, wdat[d], ewd);
            check({"wide_p_valid", s}, 512'(w_pv[d]), 512'(rvw[d]));
            check({"wide_p_data", s}, w_pd[d], rvw[d] ? rdata : '0);
            check({"narrow_p_valid", s}, 512'(n_pv[d]), 512'(rvn[d]));
            check({"narrow_p_data", s}, n_pd[d], enpd);
`ifdef HEMAIA_SB_ARB_STATS_EN
            check({"stat_wide", s}, 512'(st_w_o[d]), 512'(stw[d]));
            check({"stat_narrow", s}, 512'(st_n_o[d]), 512'(stn[d]));
`endif
            if (rst_n) begin
                rvw[d] = wg;
                rvn[d] = ng;
                if (clr) begin
                    stw[d] = 0; stn[d] = 0;
                end else begin
                    if (wv && !wg && stw[d] < 64'hFFFF_FFFF) stw[d]++;
                    if ((nv & ~ng) != 0 && stn[d] < 64'hFFFF_FFFF) stn[d]++;
                end
                if (frc[d]) begin
                    frc[d] = 0; blk[d] = 0;
                end else if (wg && nv != 0) begin
                    blk[d]++;
                    if (max_s[d] > 0 && blk[d] == max_s[d]) frc[d] = 1;
                end else begin
                    blk[d] = 0;
                end
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 0;
        idle();
        model_reset();
        @(negedge clk);
        eval();
        rst_n = 1;
    endtask

    int g0, g1, w1;

    initial begin
        idle();
        model_reset();
        rdata = '0;
        @(negedge clk);
        eval();
        rst_n = 1;

        // Wide read at 0x010
        @(negedge clk); idle(); wv = 1; wa = 10'h010; ws = '1; eval();
        @(negedge clk); idle(); eval();

        // Narrow port 2 write
        @(negedge clk); idle();
        nv[2] = 1; nw[2] = 1; na[2*AW+:AW] = 10'h155;
        nd[2*DW+:DW] = 64'hDEAD_BEEF; ns[2*8+:8] = 8'h0F; eval();
        @(negedge clk); idle(); eval();

        // Reset right after a wide read grant
        @(negedge clk); idle(); wv = 1; wa = 10'h3A0; eval();
        pulse_reset();

        // Streak pattern with wide and narrow[0] always valid
        g0 = 0; g1 = 0; w1 = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); idle(); wv = 1; nv[0] = 1; eval();
            g0 += int'(n_rdy[0][0]);
            g1 += int'(n_rdy[1][0]);
            w1 += int'(w_rdy[1]);
        end
        check("streak4_narrow_grants", 512'(g0), 512'(3));
        check("streak0_narrow_grants", 512'(g1), 512'(0));
        check("streak0_wide_grants", 512'(w1), 512'(15));

`ifdef HEMAIA_SB_ARB_STATS_EN
        @(negedge clk); idle(); clr = 1; eval();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); idle(); wv = 1; nv[0] = 1; eval();
        end
        @(negedge clk); idle(); eval();
        check("stat_narrow_10", 512'(st_n_o[1]), 512'(10));
        @(negedge clk); idle(); clr = 1; eval();
        @(negedge clk); idle(); eval();
        check("stat_narrow_clr", 512'(st_n_o[1]), 512'(0));
`endif

        for (int i = 0; i < 500; i++) begin
            @(negedge clk); rand_in(); eval();
        end
        pulse_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); rand_in(); eval();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
